// File: rtl/usrt_pkg.sv
// Shared types and helpers for the USRT receive path.
// FSM states, serial idle level and counter/pointer width helpers.
package usrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } usrt_state_e;

  localparam logic SI_IDLE = 1'b1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/usrt_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count.
// rdata reads as zero while empty.
module usrt_sync_fifo
  import usrt_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO only lands if a pop frees the slot
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rp];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/usrt_rx_fifo_param.sv
// Start-bit framed USRT receiver feeding a FWFT receive FIFO.
// Parity checking is built only when USRT_RX_PARITY_EN is defined.
module usrt_rx_fifo_param
  import usrt_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          SI,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_ferr,
  output logic                          rx_perr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          ovr,
  input  logic                          ovr_clr,
  output logic [cnt_w(FIFO_DEPTH)-1:0]  rx_count,
  output logic                          NINTI
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
`ifdef USRT_RX_PARITY_EN
  localparam int FW = DATA_W + 2;
`else
  localparam int FW = DATA_W + 1;
`endif

  usrt_state_e       state, state_n;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     pos;
  logic [DATA_W-1:0] shreg;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [FW-1:0]     wdata;
  logic [FW-1:0]     rdata;

  assign pos = (MSB_FIRST != 0) ? (LAST - idx) : idx;

  always_comb begin
    state_n = state;
    push    = 1'b0;
    unique case (state)
      IDLE:   if (SI != SI_IDLE) state_n = DATA;
`ifdef USRT_RX_PARITY_EN
      DATA:   if (idx == LAST) state_n = PARITY;
`else
      DATA:   if (idx == LAST) state_n = STOP;
`endif
      PARITY: state_n = STOP;
      STOP: begin
        state_n = IDLE;
        push    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        idx   <= '0;
        shreg <= '0;
      end
      if (state == DATA) begin
        shreg[pos] <= SI;
        idx <= (idx == LAST) ? '0 : idx + IW'(1);
      end
    end
  end

`ifdef USRT_RX_PARITY_EN
  logic perr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perr_q <= 1'b0;
    end else if (state == IDLE) begin
      perr_q <= 1'b0;
    end else if (state == PARITY) begin
      perr_q <= ((^shreg) ^ SI) != 1'(PARITY_ODD);
    end
  end

  assign wdata   = {perr_q, ~SI, shreg};
  assign rx_perr = rdata[DATA_W+1];
`else
  logic unused_par;

  assign unused_par = 1'(PARITY_ODD);
  assign wdata      = {~SI, shreg};
  assign rx_perr    = 1'b0;
`endif

  assign pop = rx_valid & rx_ready;

  // overrun only when the word truly cannot land; set beats clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovr <= 1'b0;
    end else if (push & full & ~pop) begin
      ovr <= 1'b1;
    end else if (ovr_clr) begin
      ovr <= 1'b0;
    end
  end

  usrt_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (rx_count)
  );

  assign rx_data  = rdata[DATA_W-1:0];
  assign rx_ferr  = rdata[DATA_W];
  assign rx_valid = ~empty;
  assign NINTI    = ~rx_valid;

endmodule
